// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file write-back path.
// Used by reg_wb_arbiter; pending counters saturate at PEND_MAX.
package reg_wb_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 16;
   localparam int PEND_W     = 2;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [PEND_W-1:0]     pend_cnt_t;

   localparam pend_cnt_t PEND_MAX = 2'd3;

   // Net effect of one issue and one retire; both together cancel out.
   function automatic pend_cnt_t pend_next(input pend_cnt_t cur, input logic inc, input logic dec);
      pend_cnt_t nxt;
      nxt = cur;
      if (inc && !dec) begin
         nxt = cur + 2'd1;
      end else if (dec && !inc) begin
         nxt = cur - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/reg_wb_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or after ptr, with wrap.
// The pointer moves one past the winner only when the caller signals advance.
module rr_arbiter #(
   parameter  int N     = 3,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   localparam logic [IDX_W:0]   N_W  = (IDX_W+1)'(N);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;
   logic             found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         // ptr + k folded back into 0..N-1 without a divider
         sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (sum >= N_W) begin
            sum = sum - N_W;
         end
         idx = sum[IDX_W-1:0];
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && found) begin
         ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter feeding the register file's single write port, plus an
// optional pending-write scoreboard compiled in with WB_SCOREBOARD_EN.
module reg_wb_arbiter
   import reg_wb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = REG_DATA_W,
   parameter int ADDR_W  = REG_ADDR_W
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_dst,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic                             rf_wr,
   output logic [ADDR_W-1:0]                rf_wr_dst,
   output logic [DATA_W-1:0]                rf_wr_data,
   input  logic                             issue_valid,
   input  logic [ADDR_W-1:0]                issue_dst,
   output logic                             issue_ready,
   input  logic [ADDR_W-1:0]                rd1_addr,
   input  logic [ADDR_W-1:0]                rd2_addr,
   output logic                             rd1_busy,
   output logic                             rd2_busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               xfer;

   logic               rf_wr_q, rf_wr_d;
   logic [ADDR_W-1:0]  rf_wr_dst_q, rf_wr_dst_d;
   logic [DATA_W-1:0]  rf_wr_data_q, rf_wr_data_d;

   // The write port never stalls, so any grant is a transfer.
   assign xfer      = |grant;
   assign req_ready = grant;

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (xfer),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      rf_wr_d      = xfer;
      rf_wr_dst_d  = rf_wr_dst_q;
      rf_wr_data_d = rf_wr_data_q;
      if (xfer) begin
         rf_wr_dst_d  = req_dst[grant_idx];
         rf_wr_data_d = req_data[grant_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wr_q      <= 1'b0;
         rf_wr_dst_q  <= '0;
         rf_wr_data_q <= '0;
      end else begin
         rf_wr_q      <= rf_wr_d;
         rf_wr_dst_q  <= rf_wr_dst_d;
         rf_wr_data_q <= rf_wr_data_d;
      end
   end

   assign rf_wr      = rf_wr_q;
   assign rf_wr_dst  = rf_wr_dst_q;
   assign rf_wr_data = rf_wr_data_q;

`ifdef WB_SCOREBOARD_EN
   localparam int NREG = 2 ** ADDR_W;

   pend_cnt_t cnt_q [NREG];
   pend_cnt_t cnt_d [NREG];
   logic      issue_acc;

   assign issue_ready = (cnt_q[issue_dst] != PEND_MAX);
   assign issue_acc   = issue_valid & issue_ready;

   // Retire is driven by the registered write stage, one cycle after the grant.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = pend_next(cnt_q[r],
                              issue_acc && (issue_dst == ADDR_W'(r)),
                              rf_wr_q && (rf_wr_dst_q == ADDR_W'(r)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rd1_busy = (cnt_q[rd1_addr] != '0);
   assign rd2_busy = (cnt_q[rd2_addr] != '0);

`ifndef SYNTHESIS
   retire_nonzero_a: assert property (@(posedge clk) disable iff (!rst_n)
      rf_wr_q |-> (cnt_q[rf_wr_dst_q] != '0));
`endif
`else
   logic unused_sb;

   assign unused_sb   = ^{issue_valid, issue_dst, rd1_addr, rd2_addr};
   assign issue_ready = 1'b1;
   assign rd1_busy    = 1'b0;
   assign rd2_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios, then randomized traffic,
// all compared every cycle against a queue/array-level reference model.
module tb_reg_wb_arbiter;

   localparam int N    = 3;
   localparam int AW   = 4;
   localparam int DW   = 32;
   localparam int NREG = 16;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [N-1:0]           req_valid;
   logic [N-1:0][AW-1:0]   req_dst;
   logic [N-1:0][DW-1:0]   req_data;
   logic [N-1:0]           req_ready;
   logic                   rf_wr;
   logic [AW-1:0]          rf_wr_dst;
   logic [DW-1:0]          rf_wr_data;
   logic                   issue_valid;
   logic [AW-1:0]          issue_dst;
   logic                   issue_ready;
   logic [AW-1:0]          rd1_addr, rd2_addr;
   logic                   rd1_busy, rd2_busy;

   always #5 clk = ~clk;

   reg_wb_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_dst     (req_dst),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .rf_wr       (rf_wr),
      .rf_wr_dst   (rf_wr_dst),
      .rf_wr_data  (rf_wr_data),
      .issue_valid (issue_valid),
      .issue_dst   (issue_dst),
      .issue_ready (issue_ready),
      .rd1_addr    (rd1_addr),
      .rd2_addr    (rd2_addr),
      .rd1_busy    (rd1_busy),
      .rd2_busy    (rd2_busy)
   );

   int          checks = 0;
   int          errors = 0;

   int          m_ptr;
   bit          m_wr;
   int          m_dst;
   logic [31:0] m_data;
   int          m_cnt [NREG];
   logic [N-1:0] m_gnt;
   bit          m_iss_acc;
   int          avail [NREG];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick_winner();
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr  = 0;
      m_wr   = 0;
      m_dst  = 0;
      m_data = '0;
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
   endtask

   task automatic half();
      int g;
      @(negedge clk);
      g = pick_winner();
      m_gnt = '0;
      if (g >= 0) m_gnt[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(m_gnt));
      chk("rf_wr", 64'(rf_wr), 64'(m_wr));
      chk("rf_wr_dst", 64'(rf_wr_dst), 64'(m_dst));
      chk("rf_wr_data", 64'(rf_wr_data), 64'(m_data));
`ifdef WB_SCOREBOARD_EN
      m_iss_acc = issue_valid && (m_cnt[issue_dst] != 3);
      chk("issue_ready", 64'(issue_ready), 64'(m_cnt[issue_dst] != 3));
      chk("rd1_busy", 64'(rd1_busy), 64'(m_cnt[rd1_addr] != 0));
      chk("rd2_busy", 64'(rd2_busy), 64'(m_cnt[rd2_addr] != 0));
`else
      m_iss_acc = issue_valid;
      chk("issue_ready_tied", 64'(issue_ready), 64'(1));
      chk("rd1_busy_tied", 64'(rd1_busy), 64'(0));
      chk("rd2_busy_tied", 64'(rd2_busy), 64'(0));
`endif
   endtask

   task automatic edge_();
      int g;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
`ifdef WB_SCOREBOARD_EN
         if (m_iss_acc) m_cnt[issue_dst] = m_cnt[issue_dst] + 1;
         if (m_wr) m_cnt[m_dst] = m_cnt[m_dst] - 1;
`endif
         g = pick_winner();
         if (g >= 0) begin
            m_wr   = 1;
            m_dst  = int'(req_dst[g]);
            m_data = req_data[g];
            m_ptr  = (g + 1) % N;
         end else begin
            m_wr = 0;
         end
      end
      #1;
   endtask

   task automatic cyc();
      half();
      edge_();
   endtask

   task automatic issue_n(input int dst, input int n);
      issue_valid = 1'b1;
      issue_dst   = AW'(dst);
      repeat (n) cyc();
      issue_valid = 1'b0;
   endtask

   int rr_exp [6] = '{1, 2, 3, 1, 2, 3};

   initial begin
      rst_n       = 1'b0;
      req_valid   = '0;
      req_dst     = '0;
      req_data    = '0;
      issue_valid = 1'b0;
      issue_dst   = '0;
      rd1_addr    = '0;
      rd2_addr    = '0;
      model_reset();
      repeat (2) cyc();
      chk("reset_rf_wr", 64'(rf_wr), 64'(0));
      chk("reset_issue_ready", 64'(issue_ready), 64'(1));
      chk("reset_busy", 64'({rd1_busy, rd2_busy}), 64'(0));
      rst_n = 1'b1;

      // Round-robin with all three requesters continuously valid.
      for (int k = 0; k < 6; k++) issue_n(k % 3 + 1, 1);
      req_dst[0] = 4'd1; req_dst[1] = 4'd2; req_dst[2] = 4'd3;
      req_data[0] = 32'hA000_0000; req_data[1] = 32'hA000_0001; req_data[2] = 32'hA000_0002;
`ifndef WB_SCOREBOARD_EN
      issue_valid = 1'b1;
      issue_dst   = 4'd4;
      rd1_addr    = 4'd4;
`endif
      for (int k = 0; k < 7; k++) begin
         req_valid = (k < 6) ? 3'b111 : 3'b000;
         half();
         if (k < 6) chk("rr_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
         if (k > 0) begin
            chk("rr_dst", 64'(rf_wr_dst), 64'(rr_exp[k-1]));
            chk("rr_wr", 64'(rf_wr), 64'(1));
         end
`ifndef WB_SCOREBOARD_EN
         chk("off_issue_ready", 64'(issue_ready), 64'(1));
         chk("off_busy", 64'(rd1_busy), 64'(0));
`endif
         edge_();
      end
      issue_valid = 1'b0;

      // Skip and wrap: move ptr to 2, then only requester 1 asks.
      issue_n(7, 2);
      req_valid = 3'b010; req_dst[1] = 4'd7; req_data[1] = 32'h1111_1111;
      half();
      chk("skip_first", 64'(req_ready), 64'(3'b010));
      edge_();
      req_data[1] = 32'hDEAD_BEEF;
      half();
      chk("wrap_grant", 64'(req_ready), 64'(3'b010));
      edge_();
      req_valid = '0;
      half();
      chk("wrap_wr", 64'(rf_wr), 64'(1));
      chk("wrap_dst", 64'(rf_wr_dst), 64'(7));
      chk("wrap_data", 64'(rf_wr_data), 64'(32'hDEAD_BEEF));
      edge_();

`ifdef WB_SCOREBOARD_EN
      // Scoreboard life-cycle on register 4.
      rd1_addr = 4'd4;
      issue_valid = 1'b1; issue_dst = 4'd4;
      half();
      chk("lc_idle", 64'(rd1_busy), 64'(0));
      edge_();
      issue_valid = 1'b0;
      req_valid = 3'b100; req_dst[2] = 4'd4; req_data[2] = 32'h0000_4444;
      half();
      chk("lc_busy_n", 64'(rd1_busy), 64'(1));
      chk("lc_grant", 64'(req_ready), 64'(3'b100));
      edge_();
      req_valid = '0;
      half();
      chk("lc_busy_n1", 64'(rd1_busy), 64'(1));
      edge_();
      half();
      chk("lc_busy_n2", 64'(rd1_busy), 64'(0));
      edge_();

      // Saturation on register 9 and issue colliding with a retire.
      rd2_addr = 4'd9;
      issue_n(9, 2);
      issue_valid = 1'b1; issue_dst = 4'd9;
      req_valid = 3'b001; req_dst[0] = 4'd9; req_data[0] = 32'h0000_9999;
      half();
      chk("sat_third", 64'(issue_ready), 64'(1));
      edge_();
      req_valid = '0;
      half();
      chk("sat_refuse", 64'(issue_ready), 64'(0));
      chk("sat_retire", 64'(rf_wr), 64'(1));
      chk("sat_busy", 64'(rd2_busy), 64'(1));
      edge_();
      half();
      chk("sat_accept", 64'(issue_ready), 64'(1));
      edge_();
      issue_valid = 1'b0;
      cyc();
`endif

      // Reset mid-stream with a write in flight and register 5 pending.
      rd1_addr = 4'd5;
      issue_n(5, 2);
      issue_dst = 4'd5;
      req_valid = 3'b010; req_dst[1] = 4'd5; req_data[1] = 32'h0000_5555;
      cyc();
      req_valid = '0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mr_rf_wr", 64'(rf_wr), 64'(0));
      chk("mr_busy", 64'(rd1_busy), 64'(0));
      chk("mr_issue_ready", 64'(issue_ready), 64'(1));
      cyc();
      cyc();
      rst_n = 1'b1;
      issue_n(1, 1);
      issue_n(3, 1);
      req_valid = 3'b101; req_dst[0] = 4'd1; req_dst[2] = 4'd3;
      half();
      chk("mr_first_grant", 64'(req_ready), 64'(3'b001));
      edge_();
      req_valid = 3'b100;
      cyc();
      req_valid = '0;
      cyc();
      cyc();

      // Randomized traffic; write-backs only target registers with an issue outstanding.
      for (int r = 0; r < NREG; r++) avail[r] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && ($urandom_range(0, 3) != 0)) begin
               int st;
               bit got;
               st  = int'($urandom_range(0, NREG - 1));
               got = 0;
               for (int j = 0; j < NREG; j++) begin
                  if (!got && avail[(st + j) % NREG] > 0) begin
                     got = 1;
                     avail[(st + j) % NREG] = avail[(st + j) % NREG] - 1;
                     req_valid[i] = 1'b1;
                     req_dst[i]   = AW'((st + j) % NREG);
                     req_data[i]  = $urandom;
                  end
               end
            end
         end
         issue_valid = ($urandom_range(0, 2) != 0);
         issue_dst   = AW'($urandom_range(0, 7));
         rd1_addr    = AW'($urandom_range(0, NREG - 1));
         rd2_addr    = AW'($urandom_range(0, NREG - 1));
         half();
         edge_();
         if (m_iss_acc) avail[issue_dst] = avail[issue_dst] + 1;
         req_valid = req_valid & ~m_gnt;
      end
      req_valid   = '0;
      issue_valid = 1'b0;
      repeat (3) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
